// File: rtl/ifu_prefetch.sv
// ifu_prefetch: sequential instruction prefetcher with a DEPTH-entry queue.
// Issues one word-aligned fetch per cycle while the queue has credit. It
// captures each response one cycle later together with its PC, and presents
// the queue head to decode through a valid/ready handshake. A branch redirect
// empties the queue, drops the in-flight response and restarts fetch at the
// aligned target.
module ifu_prefetch #(
    parameter int                 XLEN     = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [XLEN-1:0]    RESET_PC = '0,
    parameter logic [31:0]        NOP_WORD = 32'h00000013
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         branch_taken,
    input  logic [XLEN-1:0]              branch_target,
    output logic                         imem_req,
    output logic [XLEN-1:0]              imem_addr,
    input  logic [31:0]                  imem_rdata,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [31:0]                  Instruction_Code,
    output logic [XLEN-1:0]              instr_pc,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

    // Fetch-side control state
    logic [XLEN-1:0] r_fetch_pc;
    logic            r_pend;
    logic [XLEN-1:0] r_pend_pc;

    // Prefetch queue storage and bookkeeping
    logic [31:0]     r_q_instr [DEPTH];
    logic [XLEN-1:0] r_q_pc    [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_not_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [CW:0]     w_need;
    logic            w_room;
    logic [XLEN-1:0] w_target;

    // Handshake, credit and issue decisions for the current cycle
    always_comb begin
        w_not_empty = (r_count != '0);
        w_pop       = instr_valid & instr_ready;
        // Occupancy once the outstanding response lands and this cycle's pop
        // leaves; counting the pending word keeps the queue from overflowing.
        w_need      = {1'b0, r_count} + {{CW{1'b0}}, r_pend} - {{CW{1'b0}}, w_pop};
        w_room      = (w_need < (CW+1)'(DEPTH));
        w_issue     = ~reset & ~branch_taken & w_room;
        // A flush in the same cycle discards the arriving response.
        w_push      = r_pend & ~branch_taken & ~reset;
        w_target    = branch_target & ALIGN_MASK;
    end

    // Decode-facing outputs come from registered queue state only
    always_comb begin
        instr_valid      = w_not_empty & ~reset;
        Instruction_Code = NOP_WORD;
        instr_pc         = '0;
        if (instr_valid) begin
            Instruction_Code = r_q_instr[r_rd_ptr];
            instr_pc         = r_q_pc[r_rd_ptr];
        end
        imem_req   = w_issue;
        imem_addr  = r_fetch_pc;
        fifo_count = r_count;
    end

    // Fetch PC, pending flag and queue pointers; reset beats redirect beats normal flow
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC_ALIGNED;
            r_pend     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (branch_taken) begin
            r_fetch_pc <= w_target;
            r_pend     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            r_pend <= w_issue;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Datapath registers: PC of the outstanding request and queue payload
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_pend_pc <= r_fetch_pc;
        end
        if (w_push) begin
            r_q_instr[r_wr_ptr] <= imem_rdata;
            r_q_pc[r_wr_ptr]    <= r_pend_pc;
        end
    end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch: instance A (DEPTH=4, RESET_PC=0) and
// instance B (DEPTH=2, RESET_PC=0xFFFFFFF8) share stimulus; sel picks which
// one is observed.
module tb_ifu_prefetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        instr_ready = 1'b0;
    logic        sel = 1'b0;

    logic        req_a, valid_a, req_b, valid_b;
    logic [31:0] addr_a, code_a, pc_a, addr_b, code_b, pc_b;
    logic [31:0] rdata_a = '0, rdata_b = '0;
    logic [2:0]  count_a;
    logic [1:0]  count_b;

    logic        v_req, v_valid;
    logic [31:0] v_addr, v_code, v_pc, v_count;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] code_of(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00411083;
            32'h4:   return 32'h00322423;
            32'h8:   return 32'h407302b3;
            default: return a ^ 32'h5A5A0003;
        endcase
    endfunction

    ifu_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut_a (
        .clk(clk), .reset(reset), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(req_a), .imem_addr(addr_a),
        .imem_rdata(rdata_a), .instr_valid(valid_a), .instr_ready(instr_ready),
        .Instruction_Code(code_a), .instr_pc(pc_a), .fifo_count(count_a)
    );

    ifu_prefetch #(.XLEN(32), .DEPTH(2), .RESET_PC(32'hFFFFFFF8)) dut_b (
        .clk(clk), .reset(reset), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(req_b), .imem_addr(addr_b),
        .imem_rdata(rdata_b), .instr_valid(valid_b), .instr_ready(instr_ready),
        .Instruction_Code(code_b), .instr_pc(pc_b), .fifo_count(count_b)
    );

    // Synchronous memories: word returned one cycle after the address
    always @(posedge clk) begin
        rdata_a <= code_of(addr_a);
        rdata_b <= code_of(addr_b);
    end

    // Observation mux for the instance under test
    always_comb begin
        v_req = req_a; v_valid = valid_a; v_addr = addr_a;
        v_code = code_a; v_pc = pc_a; v_count = {29'd0, count_a};
        if (sel) begin
            v_req = req_b; v_valid = valid_b; v_addr = addr_b;
            v_code = code_b; v_pc = pc_b; v_count = {30'd0, count_b};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic b, input logic [31:0] t, input logic rdy);
        @(negedge clk);
        reset = r; branch_taken = b; branch_target = t; instr_ready = rdy;
        #1;
    endtask

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 1);
            chk("stream_valid", {31'd0, v_valid}, 1);
            chk("stream_pc", v_pc, exp_pc);
            chk("stream_code", v_code, code_of(exp_pc));
            exp_pc = exp_pc + 4;
        end
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 0);
            chk("hold_valid", {31'd0, v_valid}, 1);
            chk("hold_pc", v_pc, exp_pc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   {31'd0, v_req}, 0);
        chk({tag, "_valid"}, {31'd0, v_valid}, 0);
        chk({tag, "_code"},  v_code, 32'h00000013);
        chk({tag, "_pc"},    v_pc, 0);
        chk({tag, "_count"}, v_count, 0);
    endtask

    initial begin
        // Instance A: reset and first fetches
        sel = 1'b0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        check_reset_outputs("rst_a");
        step(0, 0, 0, 1);
        chk("R_req", {31'd0, v_req}, 1);
        chk("R_addr", v_addr, 0);
        chk("R_valid", {31'd0, v_valid}, 0);
        step(0, 0, 0, 1);
        chk("R1_addr", v_addr, 4);
        chk("R1_valid", {31'd0, v_valid}, 0);
        exp_pc = 0;
        stream(7);

        // Backpressure fills the queue, then release with no gap
        hold(10);
        chk("bp_count_a", v_count, 4);
        chk("bp_req_a", {31'd0, v_req}, 0);
        stream(8);

        // Redirect to 0x08 while full
        hold(6);
        chk("full_count_a", v_count, 4);
        step(0, 1, 32'h8, 0);
        chk("br_req", {31'd0, v_req}, 0);
        step(0, 0, 0, 1);
        chk("br1_count", v_count, 0);
        chk("br1_valid", {31'd0, v_valid}, 0);
        chk("br1_req", {31'd0, v_req}, 1);
        chk("br1_addr", v_addr, 32'h8);
        step(0, 0, 0, 1);
        chk("br2_valid", {31'd0, v_valid}, 0);
        exp_pc = 32'h8;
        stream(3);

        // Misaligned targets 0x05 and 0x07
        for (int k = 0; k < 2; k++) begin
            step(0, 1, (k == 0) ? 32'h5 : 32'h7, 1);
            chk("mis_req", {31'd0, v_req}, 0);
            step(0, 0, 0, 1);
            chk("mis_addr", v_addr, 32'h4);
            chk("mis_valid1", {31'd0, v_valid}, 0);
            step(0, 0, 0, 1);
            chk("mis_valid2", {31'd0, v_valid}, 0);
            exp_pc = 32'h4;
            stream(2);
        end

        // branch_taken held three cycles: last target wins
        step(0, 1, 32'h40, 1);
        step(0, 1, 32'h80, 1);
        chk("held_req", {31'd0, v_req}, 0);
        step(0, 1, 32'h8, 1);
        chk("held_valid", {31'd0, v_valid}, 0);
        step(0, 0, 0, 1);
        chk("held_addr", v_addr, 32'h8);
        chk("held_req2", {31'd0, v_req}, 1);
        step(0, 0, 0, 1);
        exp_pc = 32'h8;
        stream(2);

        // Reset together with branch mid-stream: reset wins
        step(1, 1, 32'h40, 1);
        chk("rb_req", {31'd0, v_req}, 0);
        step(0, 0, 0, 1);
        chk("rb_valid", {31'd0, v_valid}, 0);
        chk("rb_count", v_count, 0);
        chk("rb_addr", v_addr, 0);
        step(0, 0, 0, 1);
        exp_pc = 0;
        stream(3);

        // Instance B: DEPTH=2, wrap-around from 0xFFFFFFF8
        sel = 1'b1;
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        check_reset_outputs("rst_b");
        step(0, 0, 0, 1);
        chk("B_R_addr", v_addr, 32'hFFFFFFF8);
        chk("B_R_req", {31'd0, v_req}, 1);
        step(0, 0, 0, 1);
        chk("B_R1_addr", v_addr, 32'hFFFFFFFC);
        exp_pc = 32'hFFFFFFF8;
        stream(5);
        hold(10);
        chk("bp_count_b", v_count, 2);
        chk("bp_req_b", {31'd0, v_req}, 0);
        stream(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
